uart_rom_loader: RTL and testbench

Serial boot loader that fills the program ROM image before the wasm front-end starts. It receives an 8N1 byte stream on `rx_serial`, parses a 4-byte little-endian length header, and writes the payload bytes into the byte-wide ROM memory through its write port. It then raises `loaded`, which gates the wasm stage that reads the ROM. It sits directly upstream of the ROM memory/wasm pair in `control`.

---
 rtl/loader_pkg.sv | 33 +++
 rtl/uart_rx.sv | 144 ++++++++++++++
 rtl/uart_rom_loader.sv | 169 ++++++++++++++++
 tb/tb_uart_rom_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : loader_pkg                                             |
// | Description : Shared types and constants for the UART ROM loader.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package loader_pkg;

  // Number of little-endian length bytes that precede the payload
  localparam int HDR_BYTES = 4;

  // Width of ROM addresses, byte counts and the length field
  localparam int ADDR_W = 32;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

  // UART receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx                                                |
// | Description : 8N1 receiver with 2-flop synchronizer, mid-bit         |
// |               sampling, glitch rejection and stop-bit checking.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_serial,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err_pulse
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  rx_state_t        r_state;
  rx_state_t        w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_ferr;
  logic             w_tick_half;
  logic             w_tick_bit;
  logic             w_fall;

  assign w_tick_half = (r_cnt == CNT_W'(HALF - 1));
  assign w_tick_bit  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // A start is a high-to-low transition of the synchronized line
  assign w_fall      = r_prev & ~r_sync2;

  // Bring the asynchronous line into the clk domain; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rx_serial;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Receiver next-state: half-bit start check, 8 data bits, 1 stop bit
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_state_next = RX_START;
        end
      end
      RX_START: begin
        if (w_tick_half) begin
          // Line back high at mid start bit: treat as a glitch
          w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_tick_bit && (r_bit_idx == 3'd7)) begin
          w_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_tick_bit) begin
          w_state_next = RX_IDLE;
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  // Bit timing, LSB-first shifting and stop-bit verdict pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= 3'd0;
        end
        RX_START: begin
          r_cnt <= w_tick_half ? '0 : r_cnt + 1'b1;
        end
        RX_DATA: begin
          if (w_tick_bit) begin
            r_cnt     <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_tick_bit) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_byte_valid      = r_valid;
  assign o_byte            = r_shift;
  assign o_frame_err_pulse = r_ferr;

endmodule : uart_rx
`default_nettype wire

// File: rtl/uart_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rom_loader                                        |
// | Description : Serial boot loader: receives a 4-byte LE length header |
// |               and payload over UART, writes payload into ROM.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_rom_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int MAX_LEN      = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_serial,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data_in,
  output logic              mem_write_en,
  input  logic              mem_ready,
  output logic              loaded,
  output logic [ADDR_W-1:0] length,
  output logic              overrun,
  output logic              frame_err,
  output logic              len_err
);

  loader_state_t     r_state;
  loader_state_t     w_state_next;
  logic [1:0]        r_hdr_idx;
  logic [ADDR_W-1:0] r_length;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_overrun;
  logic              r_frame_err;
  logic              r_len_err;
  logic              w_byte_valid;
  logic [7:0]        w_byte;
  logic              w_frame_err_pulse;
  logic [ADDR_W-1:0] w_len_next;
  logic [ADDR_W-1:0] w_count_inc;
  logic              w_hdr_last;
  logic              w_len_too_big;
  logic              w_write_en;
  logic              w_loaded;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk               (clk),
    .rst               (rst),
    .i_rx_serial       (rx_serial),
    .o_byte_valid      (w_byte_valid),
    .o_byte            (w_byte),
    .o_frame_err_pulse (w_frame_err_pulse)
  );

  // Header bytes arrive LSB first, so each new byte enters at the top
  assign w_len_next    = {w_byte, r_length[ADDR_W-1:8]};
  assign w_count_inc   = r_count + 32'd1;
  assign w_hdr_last    = (r_hdr_idx == 2'(HDR_BYTES - 1));
  assign w_len_too_big = (w_len_next > ADDR_W'(MAX_LEN));

  // Loader state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Loader next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    w_write_en   = 1'b0;
    w_loaded     = 1'b0;
    case (r_state)
      ST_HDR: begin
        if (w_byte_valid && w_hdr_last) begin
          if (w_len_too_big) begin
            w_state_next = ST_ERR;
          end else if (w_len_next == '0) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_byte_valid) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_write_en = 1'b1;
        if (mem_ready) begin
          w_state_next = (w_count_inc == r_length) ? ST_DONE : ST_DATA;
        end
      end
      ST_DONE: begin
        w_loaded = 1'b1;
      end
      ST_ERR: begin
        w_state_next = ST_ERR;
      end
      default: w_state_next = ST_ERR;
    endcase
  end

  // Header assembly, write latching, byte counting and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr_idx   <= 2'd0;
      r_length    <= '0;
      r_count     <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= 8'd0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      if (w_frame_err_pulse) begin
        r_frame_err <= 1'b1;
      end
      case (r_state)
        ST_HDR: begin
          if (w_byte_valid) begin
            r_length  <= w_len_next;
            r_hdr_idx <= r_hdr_idx + 2'd1;
            if (w_hdr_last && w_len_too_big) begin
              r_len_err <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_byte_valid) begin
            r_mem_data <= w_byte;
            r_mem_addr <= r_count;
          end
        end
        ST_WRITE: begin
          // Write in flight: a new byte cannot be buffered, so it is lost
          if (w_byte_valid) begin
            r_overrun <= 1'b1;
          end
          if (mem_ready) begin
            r_count <= w_count_inc;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_data_in  = r_mem_data;
  assign mem_write_en = w_write_en;
  assign loaded       = w_loaded;
  assign length       = r_length;
  assign overrun      = r_overrun;
  assign frame_err    = r_frame_err;
  assign len_err      = r_len_err;

endmodule : uart_rom_loader
`default_nettype wire

// File: tb/tb_uart_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_rom_loader                                     |
// | Description : Directed self-checking bench for uart_rom_loader.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_uart_rom_loader;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic        mem_write_en;
  logic        mem_ready;
  logic        loaded;
  logic [31:0] length;
  logic        overrun;
  logic        frame_err;
  logic        len_err;

  int          checks = 0;
  int          errors = 0;
  int          we_cycles = 0;
  logic [39:0] wr_q[$];

  uart_rom_loader #(
    .CLKS_PER_BIT (4),
    .MAX_LEN      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_ready    (mem_ready),
    .loaded       (loaded),
    .length       (length),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .len_err      (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted write as {addr, data} and count enable cycles
  always @(posedge clk) begin
    if (!rst && mem_write_en) begin
      we_cycles++;
      if (mem_ready) begin
        wr_q.push_back({mem_addr, mem_data_in});
      end
    end
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8N1 frame, 4 clocks per bit, driven from a falling clock edge
  task automatic send_byte(input logic [7:0] b, input logic stop_level);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (4) @(negedge clk);
    end
    rx = stop_level;
    repeat (4) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int wbase;
    int ebase;
    rst = 1'b1;
    rx = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_we", 40'(mem_write_en), 40'd0);
    chk("rst_addr", 40'(mem_addr), 40'd0);
    chk("rst_data", 40'(mem_data_in), 40'd0);
    chk("rst_loaded", 40'(loaded), 40'd0);
    chk("rst_length", 40'(length), 40'd0);
    chk("rst_flags", 40'({overrun, frame_err, len_err}), 40'd0);

    // Three-byte image with memory always ready
    wbase = wr_q.size();
    ebase = we_cycles;
    send_hdr(8'h03, 8'h00, 8'h00, 8'h00);
    send_byte(8'hAA, 1'b1);
    @(negedge clk);
    chk("s1_we_at_valid", 40'(mem_write_en), 40'd0);
    @(negedge clk);
    chk("s1_we_rise", 40'(mem_write_en), 40'd1);
    chk("s1_we_addr", 40'(mem_addr), 40'd0);
    chk("s1_we_data", 40'(mem_data_in), 40'hAA);
    @(negedge clk);
    chk("s1_we_fall", 40'(mem_write_en), 40'd0);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    repeat (6) @(negedge clk);
    chk("s1_nwrites", 40'(wr_q.size() - wbase), 40'd3);
    chk("s1_we_cycles", 40'(we_cycles - ebase), 40'd3);
    chk("s1_w0", wr_q[wbase + 0], {32'd0, 8'hAA});
    chk("s1_w1", wr_q[wbase + 1], {32'd1, 8'hBB});
    chk("s1_w2", wr_q[wbase + 2], {32'd2, 8'hCC});
    chk("s1_loaded", 40'(loaded), 40'd1);
    chk("s1_length", 40'(length), 40'd3);
    chk("s1_flags", 40'({overrun, frame_err, len_err}), 40'd0);

    // Zero-length image
    do_reset();
    ebase = we_cycles;
    send_hdr(8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("s2_loaded_at_valid", 40'(loaded), 40'd0);
    @(negedge clk);
    chk("s2_loaded_next", 40'(loaded), 40'd1);
    repeat (4) @(negedge clk);
    chk("s2_no_we", 40'(we_cycles - ebase), 40'd0);
    chk("s2_length", 40'(length), 40'd0);

    // Oversized header: terminal error
    do_reset();
    ebase = we_cycles;
    send_hdr(8'h20, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    chk("s3_len_err", 40'(len_err), 40'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    repeat (6) @(negedge clk);
    chk("s3_no_we", 40'(we_cycles - ebase), 40'd0);
    chk("s3_loaded", 40'(loaded), 40'd0);
    chk("s3_length", 40'(length), 40'd32);

    // Stalled write with back-to-back payload: second byte overruns
    do_reset();
    mem_ready = 1'b0;
    wbase = wr_q.size();
    send_hdr(8'h02, 8'h00, 8'h00, 8'h00);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    chk("s4_we_held", 40'(mem_write_en), 40'd1);
    chk("s4_addr_held", 40'(mem_addr), 40'd0);
    chk("s4_data_held", 40'(mem_data_in), 40'h11);
    chk("s4_overrun", 40'(overrun), 40'd1);
    mem_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("s4_we_drop", 40'(mem_write_en), 40'd0);
    chk("s4_nwrites", 40'(wr_q.size() - wbase), 40'd1);
    chk("s4_w0", wr_q[wbase + 0], {32'd0, 8'h11});
    chk("s4_loaded", 40'(loaded), 40'd0);

    // Framing error followed by a valid one-byte image
    do_reset();
    wbase = wr_q.size();
    send_byte(8'h77, 1'b0);
    repeat (8) @(negedge clk);
    chk("s5_frame_err", 40'(frame_err), 40'd1);
    send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
    send_byte(8'h5A, 1'b1);
    repeat (6) @(negedge clk);
    chk("s5_nwrites", 40'(wr_q.size() - wbase), 40'd1);
    chk("s5_w0", wr_q[wbase + 0], {32'd0, 8'h5A});
    chk("s5_loaded", 40'(loaded), 40'd1);
    chk("s5_length", 40'(length), 40'd1);
    chk("s5_len_err", 40'(len_err), 40'd0);

    // Reset in the middle of a pending write, then a clean reload
    do_reset();
    mem_ready = 1'b0;
    send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
    send_byte(8'h33, 1'b1);
    repeat (2) @(negedge clk);
    chk("s6_we_before", 40'(mem_write_en), 40'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("s6_we", 40'(mem_write_en), 40'd0);
    chk("s6_addr", 40'(mem_addr), 40'd0);
    chk("s6_data", 40'(mem_data_in), 40'd0);
    chk("s6_loaded", 40'(loaded), 40'd0);
    chk("s6_length", 40'(length), 40'd0);
    chk("s6_flags", 40'({overrun, frame_err, len_err}), 40'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    wbase = wr_q.size();
    send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
    send_byte(8'h44, 1'b1);
    repeat (6) @(negedge clk);
    chk("s6_nwrites", 40'(wr_q.size() - wbase), 40'd1);
    chk("s6_w0", wr_q[wbase + 0], {32'd0, 8'h44});
    chk("s6_reload", 40'(loaded), 40'd1);
    chk("s6_relength", 40'(length), 40'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rom_loader
`default_nettype wire
